// File: rtl/ddr3_rd_burst_assembler_pkg.sv
// Shared constants and capture-FSM encoding for the DDR3 read burst assembler.
package ddr3_rd_burst_assembler_pkg;

  localparam int unsigned Bl            = 8;  // DDR3 burst length
  localparam int unsigned BeatsPerBurst = 2;  // SCLK beats per BL8 burst
  localparam int unsigned BitsPerBeat   = 4;  // gearbox bits per lane per SCLK
  localparam int unsigned LatW          = 5;  // width of the read-latency setting

  typedef logic [LatW-1:0] lat_t;

  typedef enum logic [1:0] {
    StIdle,
    StBeat1,
    StDone
  } cap_state_e;

endpackage

// File: rtl/ddr3_rd_burst_assembler_if.sv
// Command, gearbox data and returned-burst signals of the read burst assembler.
interface ddr3_rd_burst_assembler_if
  import ddr3_rd_burst_assembler_pkg::*;
#(
  parameter int unsigned DQ_W  = 16,
  parameter int unsigned TAG_W = 4
);

  logic                        rd_issue;
  logic [TAG_W-1:0]            rd_tag;
  lat_t                        rd_lat;
  logic [BitsPerBeat*DQ_W-1:0] dq_q;
  logic                        rd_valid;
  logic [Bl*DQ_W-1:0]          rd_data;
  logic [TAG_W-1:0]            rd_tag_out;
  logic                        busy;
  logic                        err_ovf;
  logic                        err_proto;

  // Controller / gearbox side
  modport master (
    output rd_issue, rd_tag, rd_lat, dq_q,
    input  rd_valid, rd_data, rd_tag_out, busy, err_ovf, err_proto
  );

  // Assembler side
  modport slave (
    input  rd_issue, rd_tag, rd_lat, dq_q,
    output rd_valid, rd_data, rd_tag_out, busy, err_ovf, err_proto
  );

endinterface

// File: rtl/ddr3_tag_fifo.sv
// Synchronous tag FIFO; a pop frees its slot for a push in the same cycle.
module ddr3_tag_fifo #(
  parameter int unsigned Width = 4,
  parameter int unsigned Depth = 4
) (
  input  logic             SCLK,
  input  logic             RST,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // Pointer/count/storage next state; pointers wrap naturally (Depth is a power of 2)
  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = wr_ptr_q + PtrW'(do_push);
    rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
    cnt_d    = cnt_q + CntW'(do_push) - CntW'(do_pop);
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
    end
  end

  // State registers
  always_ff @(posedge SCLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/ddr3_rd_burst_assembler.sv
// Tracks READs through a latency delay line, captures both SCLK beats of each BL8
// burst and returns the reordered burst with its tag, in issue order.
module ddr3_rd_burst_assembler
  import ddr3_rd_burst_assembler_pkg::*;
#(
  parameter int unsigned DQ_W      = 16,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned TAG_DEPTH = 4,
  parameter int unsigned LAT_MAX   = 31
) (
  input  logic                      SCLK,
  input  logic                      RST,
  ddr3_rd_burst_assembler_if.slave  bus
);

  logic                        accept, can_push, s0, rd_valid;
  logic                        fifo_full, fifo_empty;
  logic [TAG_W-1:0]            fifo_head;
  logic                        acc_last_q, acc_last_d;
  logic [LAT_MAX-1:0]          dl_q, dl_d;
  cap_state_e                  state_q, state_d;
  logic                        cap_beat0, cap_beat1;
  logic [BitsPerBeat*DQ_W-1:0] beat0_q, beat0_d;
  logic [Bl*DQ_W-1:0]          data_q, data_d, burst_asm;
  logic [TAG_W-1:0]            tag_q, tag_d;
  logic                        ovf_q, ovf_d, proto_q, proto_d;

  ddr3_tag_fifo #(
    .Width (TAG_W),
    .Depth (TAG_DEPTH)
  ) u_tag_fifo (
    .SCLK    (SCLK),
    .RST     (RST),
    .push_i  (accept),
    .data_i  (bus.rd_tag),
    .pop_i   (rd_valid),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Issue acceptance, sticky errors and delay-line shift
  always_comb begin
    can_push   = !fifo_full || rd_valid;
    accept     = bus.rd_issue && can_push && !acc_last_q;
    acc_last_d = accept;
    ovf_d      = ovf_q | (bus.rd_issue && !can_push);
    proto_d    = proto_q | (bus.rd_issue && acc_last_q);
    dl_d       = {dl_q[LAT_MAX-2:0], accept};
  end

  // Beat-0 strobe: delay-line tap selected by the programmed latency
  always_comb begin
    s0 = 1'b0;
    for (int j = 0; j < LAT_MAX; j++) begin
      if (int'(bus.rd_lat) == j + 1) begin
        s0 = dl_q[j];
      end
    end
  end

  // Capture FSM state register
  always_ff @(posedge SCLK) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture FSM next state; DONE chains straight into a new burst
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = s0 ? StBeat1 : StIdle;
      StBeat1: state_d = StDone;
      StDone:  state_d = s0 ? StBeat1 : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Capture FSM outputs
  always_comb begin
    cap_beat0 = 1'b0;
    cap_beat1 = 1'b0;
    rd_valid  = 1'b0;
    unique case (state_q)
      StIdle:  cap_beat0 = s0;
      StBeat1: cap_beat1 = 1'b1;
      StDone: begin
        rd_valid  = 1'b1;
        cap_beat0 = s0;
      end
      default: ;
    endcase
  end

  // Lane-major gearbox nibbles to burst-major word: bit k of lane i -> k*DQ_W+i
  always_comb begin
    burst_asm = '0;
    for (int k = 0; k < BitsPerBeat; k++) begin
      for (int i = 0; i < DQ_W; i++) begin
        burst_asm[k*DQ_W + i]                 = beat0_q[BitsPerBeat*i + k];
        burst_asm[(k+BitsPerBeat)*DQ_W + i]   = bus.dq_q[BitsPerBeat*i + k];
      end
    end
  end

  // Datapath next state: beat-0 hold, burst/tag capture on the second beat
  always_comb begin
    beat0_d = cap_beat0 ? bus.dq_q : beat0_q;
    data_d  = cap_beat1 ? burst_asm : data_q;
    tag_d   = cap_beat1 ? fifo_head : tag_q;
  end

  // Datapath and control registers
  always_ff @(posedge SCLK) begin
    if (RST) begin
      acc_last_q <= 1'b0;
      dl_q       <= '0;
      beat0_q    <= '0;
      data_q     <= '0;
      tag_q      <= '0;
      ovf_q      <= 1'b0;
      proto_q    <= 1'b0;
    end else begin
      acc_last_q <= acc_last_d;
      dl_q       <= dl_d;
      beat0_q    <= beat0_d;
      data_q     <= data_d;
      tag_q      <= tag_d;
      ovf_q      <= ovf_d;
      proto_q    <= proto_d;
    end
  end

  assign bus.rd_valid   = rd_valid;
  assign bus.rd_data    = data_q;
  assign bus.rd_tag_out = tag_q;
  assign bus.busy       = !fifo_empty || (|dl_q);
  assign bus.err_ovf    = ovf_q;
  assign bus.err_proto  = proto_q;

endmodule

// File: tb/tb_ddr3_rd_burst_assembler.sv
// Self-checking bench: queue-based read model plus directed literal checks.
module tb_ddr3_rd_burst_assembler;
  import ddr3_rd_burst_assembler_pkg::*;

  localparam int DQ_W      = 16;
  localparam int TAG_W     = 4;
  localparam int TAG_DEPTH = 4;
  localparam int LAT_MAX   = 31;
  localparam int HIST      = 4096;

  logic SCLK = 1'b0;
  logic RST;

  ddr3_rd_burst_assembler_if #(.DQ_W(DQ_W), .TAG_W(TAG_W)) bus ();

  ddr3_rd_burst_assembler #(
    .DQ_W      (DQ_W),
    .TAG_W     (TAG_W),
    .TAG_DEPTH (TAG_DEPTH),
    .LAT_MAX   (LAT_MAX)
  ) dut (
    .SCLK (SCLK),
    .RST  (RST),
    .bus  (bus)
  );

  always #5 SCLK = ~SCLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int               t;
    int               lat;
    logic [TAG_W-1:0] tag;
  } rd_t;

  rd_t                 pq[$];
  logic [4*DQ_W-1:0]   hist [HIST];
  int                  cyc      = 0;
  int                  last_acc = -1000;
  logic                m_valid  = 1'b0;
  logic                m_ovf    = 1'b0;
  logic                m_proto  = 1'b0;
  logic [8*DQ_W-1:0]   m_data   = '0;
  logic [TAG_W-1:0]    m_tag    = '0;
  int                  vcnt     = 0;
  bit                  chk_en   = 1'b0;

  // Read model: a read accepted in cycle t returns in cycle t+lat+2, built from the
  // dq_q words of cycles t+lat and t+lat+1, and leaves the queue at the end of that cycle.
  always @(posedge SCLK) begin : model
    int  cur;
    bit  pop_now;
    bit  can_push;
    rd_t r;
    cur = cyc;
    hist[cur % HIST] = bus.dq_q;
    if (RST) begin
      pq.delete();
      m_ovf    = 1'b0;
      m_proto  = 1'b0;
      m_data   = '0;
      m_tag    = '0;
      last_acc = -1000;
    end else begin
      pop_now = (pq.size() > 0) && (pq[0].t + pq[0].lat + 2 == cur);
      if (pop_now) void'(pq.pop_front());
      can_push = (pq.size() < TAG_DEPTH);
      if (bus.rd_issue) begin
        if (!can_push) m_ovf = 1'b1;
        if (last_acc == cur - 1) m_proto = 1'b1;
        if (can_push && last_acc != cur - 1) begin
          r.t   = cur;
          r.lat = int'(bus.rd_lat);
          r.tag = bus.rd_tag;
          pq.push_back(r);
          last_acc = cur;
        end
      end
    end
    cyc = cur + 1;
    m_valid = 1'b0;
    if (pq.size() > 0 && pq[0].t + pq[0].lat + 2 == cyc) begin
      m_valid = 1'b1;
      m_tag   = pq[0].tag;
      for (int k = 0; k < 8; k++) begin
        for (int i = 0; i < DQ_W; i++) begin
          m_data[k*DQ_W + i] = hist[(pq[0].t + pq[0].lat + k/4) % HIST][4*i + k%4];
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge SCLK) begin
    if (chk_en) begin
      chk("rd_valid",   128'(bus.rd_valid),   128'(m_valid));
      chk("rd_data",    128'(bus.rd_data),    128'(m_data));
      chk("rd_tag_out", 128'(bus.rd_tag_out), 128'(m_tag));
      chk("busy",       128'(bus.busy),
          128'((pq.size() > 0) || (cyc - last_acc <= LAT_MAX)));
      chk("err_ovf",    128'(bus.err_ovf),    128'(m_ovf));
      chk("err_proto",  128'(bus.err_proto),  128'(m_proto));
      if (bus.rd_valid) vcnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge SCLK);
    #1;
    bus.dq_q = {$urandom(), $urandom()};
  endtask

  task automatic issue(input logic [TAG_W-1:0] tag);
    bus.rd_issue = 1'b1;
    bus.rd_tag   = tag;
    tick();
    bus.rd_issue = 1'b0;
  endtask

  function automatic logic [7:0] lane0();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = bus.rd_data[k*DQ_W];
    return v;
  endfunction

  initial begin
    int v0;
    RST          = 1'b1;
    bus.rd_issue = 1'b0;
    bus.rd_tag   = '0;
    bus.rd_lat   = 5'd6;
    bus.dq_q     = '0;
    repeat (3) tick();
    RST = 1'b0;

    // Reset state
    chk("rst_valid", 128'(bus.rd_valid), 128'(0));
    chk("rst_data",  128'(bus.rd_data),  128'(0));
    chk("rst_tag",   128'(bus.rd_tag_out), 128'(0));
    chk("rst_busy",  128'(bus.busy),     128'(0));
    chk("rst_errs",  128'({bus.err_ovf, bus.err_proto}), 128'(0));
    chk_en = 1'b1;

    // 1: single read, lat 6, known lane-0 beats
    issue(4'd3);
    repeat (5) tick();
    bus.dq_q[3:0] = 4'b1010;
    tick();
    chk("t1_early", 128'(bus.rd_valid), 128'(0));
    bus.dq_q[3:0] = 4'b0110;
    tick();
    chk("t1_valid", 128'(bus.rd_valid), 128'(1));
    chk("t1_tag",   128'(bus.rd_tag_out), 128'(3));
    chk("t1_lane0", 128'(lane0()), 128'(8'b0110_1010));

    // 2: three reads spaced 2 cycles
    repeat (40) tick();
    issue(4'd1); tick();
    issue(4'd2); tick();
    issue(4'd3);
    repeat (3) tick();
    chk("t2_v1",   128'(bus.rd_valid), 128'(1));
    chk("t2_tag1", 128'(bus.rd_tag_out), 128'(1));
    tick();
    chk("t2_gap1", 128'(bus.rd_valid), 128'(0));
    tick();
    chk("t2_v2",   128'(bus.rd_valid), 128'(1));
    chk("t2_tag2", 128'(bus.rd_tag_out), 128'(2));
    tick();
    chk("t2_gap2", 128'(bus.rd_valid), 128'(0));
    tick();
    chk("t2_v3",   128'(bus.rd_valid), 128'(1));
    chk("t2_tag3", 128'(bus.rd_tag_out), 128'(3));

    // 3: back-to-back issue, second dropped
    repeat (40) tick();
    v0 = vcnt;
    bus.rd_issue = 1'b1; bus.rd_tag = 4'd5;
    tick();
    bus.rd_tag = 4'd6;
    tick();
    bus.rd_issue = 1'b0;
    chk("t3_proto", 128'(bus.err_proto), 128'(1));
    repeat (20) tick();
    chk("t3_nvalid", 128'(vcnt - v0), 128'(1));

    // 4: lat 31, five reads, fifth overflows
    repeat (40) tick();
    bus.rd_lat = 5'd31;
    v0 = vcnt;
    for (int j = 0; j < 5; j++) begin
      issue(4'(j + 8));
      tick();
    end
    chk("t4_ovf", 128'(bus.err_ovf), 128'(1));
    repeat (45) tick();
    chk("t4_nvalid", 128'(vcnt - v0), 128'(4));

    // 5: reset between beat0 and beat1
    repeat (5) tick();
    bus.rd_lat = 5'd6;
    v0 = vcnt;
    issue(4'd7);
    repeat (6) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("t5_busy",  128'(bus.busy), 128'(0));
    chk("t5_errs",  128'({bus.err_ovf, bus.err_proto}), 128'(0));
    chk("t5_valid", 128'(bus.rd_valid), 128'(0));
    repeat (20) tick();
    chk("t5_nvalid", 128'(vcnt - v0), 128'(0));

    // 6: latency sweep with random tags, data and spacing
    for (int lat = 2; lat <= LAT_MAX; lat++) begin
      repeat (40) tick();
      bus.rd_lat = 5'(lat);
      for (int j = 0; j < int'($urandom_range(2, 5)); j++) begin
        issue(4'($urandom_range(0, 15)));
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    repeat (45) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
